// File: rtl/riscv_pkg.sv
// Shared types for the multicycle RV64 control path: opcodes, FSM states,
// datapath select encodings and the per-state control word decoder.
package riscv_pkg;

    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_ALU_WB    = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_TRAP      = 4'd9
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'b00,
        SRC_A_OLDPC = 2'b01,
        SRC_A_REG   = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRC_B_REG  = 2'b00,
        SRC_B_FOUR = 2'b01,
        SRC_B_IMM  = 2'b10
    } src_b_t;

    // fetch/branch mark the states whose PC enable is gated by an input
    typedef struct packed {
        logic    mem_req;
        logic    mem_we;
        logic    iord;
        logic    fetch;
        logic    branch;
        logic    pc_src;
        src_a_t  src_a;
        src_b_t  src_b;
        alu_op_t alu_op;
        logic    reg_write;
        logic    mem_to_reg;
        logic    halted;
    } ctrl_word_t;

    function automatic ctrl_word_t ctrl_decode(input ctrl_state_t state);
        ctrl_word_t w;
        w = '0;
        case (state)
            ST_FETCH: begin
                w.mem_req = 1'b1;
                w.fetch   = 1'b1;
                w.src_a   = SRC_A_PC;
                w.src_b   = SRC_B_FOUR;
                w.alu_op  = ALU_ADD;
            end
            ST_DECODE: begin
                w.src_a  = SRC_A_OLDPC;
                w.src_b  = SRC_B_IMM;
                w.alu_op = ALU_ADD;
            end
            ST_MEM_ADDR: begin
                w.src_a  = SRC_A_REG;
                w.src_b  = SRC_B_IMM;
                w.alu_op = ALU_ADD;
            end
            ST_MEM_READ: begin
                w.mem_req = 1'b1;
                w.iord    = 1'b1;
            end
            ST_MEM_WB: begin
                w.reg_write  = 1'b1;
                w.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                w.mem_req = 1'b1;
                w.iord    = 1'b1;
                w.mem_we  = 1'b1;
            end
            ST_EXECUTE: begin
                w.src_a  = SRC_A_REG;
                w.src_b  = SRC_B_REG;
                w.alu_op = ALU_FUNCT;
            end
            ST_ALU_WB: begin
                w.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                w.branch = 1'b1;
                w.pc_src = 1'b1;
                w.src_a  = SRC_A_REG;
                w.src_b  = SRC_B_REG;
                w.alu_op = ALU_SUB;
            end
            ST_TRAP: begin
                w.halted = 1'b1;
            end
            default: begin
                w = '0;
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory request handshake between the controller
// and the memory port.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/retire_counter.sv
// Retired-instruction counter: async reset, wraps to zero on overflow.
module retire_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count one per enabled cycle; natural overflow provides the wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV64 datapath (ld/sd/beq/R-type),
// with memory handshake, branch resolution, illegal-opcode trap and retire count.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_ctrl_if.master    mem,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    output logic                 ir_write,
    output logic                 pc_en,
    output logic                 pc_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired
);

    ctrl_state_t state_r;
    ctrl_state_t state_next_s;
    ctrl_word_t  ctrl_r;
    ctrl_word_t  ctrl_s;
    logic        retire_s;

    // Next-state selection; mem_ready only matters in the request states.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (mem.mem_ready) state_next_s = ST_DECODE;
                else               state_next_s = ST_FETCH;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LD, OP_SD: state_next_s = ST_MEM_ADDR;
                    OP_RTYPE:     state_next_s = ST_EXECUTE;
                    OP_BEQ:       state_next_s = ST_BRANCH;
                    default:      state_next_s = ST_TRAP;
                endcase
            end
            ST_MEM_ADDR: begin
                if (opcode == OP_LD) state_next_s = ST_MEM_READ;
                else                 state_next_s = ST_MEM_WRITE;
            end
            ST_MEM_READ: begin
                if (mem.mem_ready) state_next_s = ST_MEM_WB;
                else               state_next_s = ST_MEM_READ;
            end
            ST_MEM_WRITE: begin
                if (mem.mem_ready) state_next_s = ST_FETCH;
                else               state_next_s = ST_MEM_WRITE;
            end
            ST_MEM_WB:  state_next_s = ST_FETCH;
            ST_EXECUTE: state_next_s = ST_ALU_WB;
            ST_ALU_WB:  state_next_s = ST_FETCH;
            ST_BRANCH:  state_next_s = ST_FETCH;
            ST_TRAP:    state_next_s = ST_TRAP;
            default:    state_next_s = ST_TRAP;
        endcase
    end

    // State and its control word are registered together from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FETCH;
            ctrl_r  <= ctrl_decode(ST_FETCH);
        end else begin
            state_r <= state_next_s;
            ctrl_r  <= ctrl_decode(state_next_s);
        end
    end

    // The word already holds FETCH during reset, so reset itself masks it to zero.
    always_comb begin
        if (reset) begin
            ctrl_s = '0;
        end else begin
            ctrl_s = ctrl_r;
        end
    end

    assign retire_s = (state_r == ST_MEM_WB) || (state_r == ST_ALU_WB) ||
                      (state_r == ST_BRANCH) ||
                      ((state_r == ST_MEM_WRITE) && mem.mem_ready);

    retire_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_retire (
        .clk   (clk),
        .reset (reset),
        .en    (retire_s),
        .count (retired)
    );

    assign mem.mem_req = ctrl_s.mem_req;
    assign mem.mem_we  = ctrl_s.mem_we;
    assign mem.iord    = ctrl_s.iord;
    assign ir_write    = ctrl_s.fetch & mem.mem_ready;
    assign pc_en       = (ctrl_s.fetch & mem.mem_ready) | (ctrl_s.branch & zero);
    assign pc_src      = ctrl_s.pc_src;
    assign alu_src_a   = ctrl_s.src_a;
    assign alu_src_b   = ctrl_s.src_b;
    assign alu_op      = ctrl_s.alu_op;
    assign reg_write   = ctrl_s.reg_write;
    assign mem_to_reg  = ctrl_s.mem_to_reg;
    assign halted      = ctrl_s.halted;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (4-bit retire counter).
module tb_multicycle_ctrl;

    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_SD  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_RT  = 7'b0110011;
    localparam logic [6:0] OPC_ILL = 7'b0010011;

    // {mem_req, mem_we, iord, ir_write, pc_en, pc_src, src_a, src_b, alu_op, reg_write, mem_to_reg, halted}
    localparam logic [14:0] E_ZERO       = 15'b0;
    localparam logic [14:0] E_FETCH_RDY  = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_FETCH_WAIT = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_DECODE     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_MEM_ADDR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_MEM_READ   = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_MEM_WB     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
    localparam logic [14:0] E_MEM_WRITE  = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_EXECUTE    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_ALU_WB     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
    localparam logic [14:0] E_BR_TAKEN   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_BR_NOT     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
    localparam logic [14:0] E_TRAP       = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};

    // Which fields a state actually defines; the rest are don't-care.
    localparam logic [14:0] K_ALL   = 15'b111_111_11_11_11_111;
    localparam logic [14:0] K_FETCH = 15'b111_111_11_11_11_101;
    localparam logic [14:0] K_ALU   = 15'b111_110_11_11_11_101;
    localparam logic [14:0] K_WB    = 15'b111_110_00_00_00_111;
    localparam logic [14:0] K_CTL   = 15'b111_110_00_00_00_101;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        ir_write;
    logic        pc_en;
    logic        pc_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic        mem_to_reg;
    logic        halted;
    logic [3:0]  retired;
    logic [14:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .CNT_WIDTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem        (bus),
        .opcode     (opcode),
        .zero       (zero),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .halted     (halted),
        .retired    (retired)
    );

    assign obs = {bus.mem_req, bus.mem_we, bus.iord, ir_write, pc_en, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [14:0] exp, input logic [14:0] mask);
        n_checks++;
        assert ((obs & mask) === (exp & mask)) else begin
            n_fail++;
            $error("FAIL %s: outputs %b, required %b (mask %b)", tag, obs & mask, exp & mask, mask);
        end
    endtask

    task automatic check_ret(input string tag, input logic [3:0] exp);
        n_checks++;
        assert (retired === exp) else begin
            n_fail++;
            $error("FAIL %s: retired %0d, required %0d", tag, retired, exp);
        end
    endtask

    // One FSM cycle: drive mem_ready, check mid-cycle, step to just past the next edge.
    task automatic cyc(input string tag, input logic rdy, input logic [14:0] exp, input logic [14:0] mask);
        bus.mem_ready = rdy;
        @(negedge clk);
        check_vec(tag, exp, mask);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        opcode        = OPC_RT;
        zero          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("reset_outputs", E_ZERO, K_ALL);
        check_ret("reset_retired", 4'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // R-type, no waits: 4 cycles
        cyc("rt_fetch",  1'b1, E_FETCH_RDY, K_FETCH);
        cyc("rt_decode", 1'b1, E_DECODE,    K_ALU);
        cyc("rt_exec",   1'b1, E_EXECUTE,   K_ALU);
        check_ret("rt_retired_before_wb", 4'd0);
        cyc("rt_alu_wb", 1'b1, E_ALU_WB,    K_WB);
        check_ret("rt_retired", 4'd1);

        // ld with two data wait cycles: 7 cycles
        opcode = OPC_LD;
        cyc("ld_fetch",  1'b1, E_FETCH_RDY, K_FETCH);
        cyc("ld_decode", 1'b1, E_DECODE,    K_ALU);
        cyc("ld_addr",   1'b1, E_MEM_ADDR,  K_ALU);
        cyc("ld_wait1",  1'b0, E_MEM_READ,  K_CTL);
        cyc("ld_wait2",  1'b0, E_MEM_READ,  K_CTL);
        cyc("ld_read",   1'b1, E_MEM_READ,  K_CTL);
        check_ret("ld_retired_before_wb", 4'd1);
        cyc("ld_wb",     1'b1, E_MEM_WB,    K_WB);
        check_ret("ld_retired", 4'd2);

        // beq taken then not taken: 3 cycles each
        opcode = OPC_BEQ;
        zero   = 1'b1;
        cyc("beq1_fetch",  1'b1, E_FETCH_RDY, K_FETCH);
        cyc("beq1_decode", 1'b1, E_DECODE,    K_ALU);
        cyc("beq1_branch", 1'b1, E_BR_TAKEN,  K_FETCH);
        check_ret("beq1_retired", 4'd3);
        zero = 1'b0;
        cyc("beq0_fetch",  1'b1, E_FETCH_RDY, K_FETCH);
        cyc("beq0_decode", 1'b1, E_DECODE,    K_ALU);
        cyc("beq0_branch", 1'b1, E_BR_NOT,    K_FETCH);
        check_ret("beq0_retired", 4'd4);

        // sd with one fetch wait: 5 cycles
        opcode = OPC_SD;
        cyc("sd_fetch_wait", 1'b0, E_FETCH_WAIT, K_FETCH);
        cyc("sd_fetch",      1'b1, E_FETCH_RDY,  K_FETCH);
        cyc("sd_decode",     1'b1, E_DECODE,     K_ALU);
        cyc("sd_addr",       1'b1, E_MEM_ADDR,   K_ALU);
        cyc("sd_write",      1'b1, E_MEM_WRITE,  K_CTL);
        check_ret("sd_retired", 4'd5);

        // reset asserted in the middle of a pending store
        cyc("sdr_fetch",  1'b1, E_FETCH_RDY, K_FETCH);
        cyc("sdr_decode", 1'b1, E_DECODE,    K_ALU);
        cyc("sdr_addr",   1'b1, E_MEM_ADDR,  K_ALU);
        bus.mem_ready = 1'b0;
        #2;
        check_vec("sdr_write_pending", E_MEM_WRITE, K_CTL);
        reset = 1'b1;
        #1;
        check_vec("sdr_async_drop", E_ZERO, K_ALL);
        check_ret("sdr_async_retired", 4'd0);
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("sdr_after_fetch", 1'b0, E_FETCH_WAIT, K_FETCH);
        check_ret("sdr_after_retired", 4'd0);

        // retire one beq, then an illegal opcode traps for good
        opcode = OPC_BEQ;
        zero   = 1'b1;
        cyc("pre_trap_fetch",  1'b1, E_FETCH_RDY, K_FETCH);
        cyc("pre_trap_decode", 1'b1, E_DECODE,    K_ALU);
        cyc("pre_trap_branch", 1'b1, E_BR_TAKEN,  K_FETCH);
        opcode = OPC_ILL;
        cyc("ill_fetch",  1'b1, E_FETCH_RDY, K_FETCH);
        cyc("ill_decode", 1'b1, E_DECODE,    K_ALU);
        for (int i = 0; i < 20; i++) begin
            cyc("trap_hold", i[0], E_TRAP, K_CTL);
            check_ret("trap_retired", 4'd1);
        end
        reset = 1'b1;
        #1;
        check_vec("trap_reset_clears", E_ZERO, K_ALL);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_ret("wrap_start", 4'd0);

        // 16 back-to-back stores: retired counts 1..15 then wraps to 0
        opcode = OPC_SD;
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] exp_cnt;
            exp_cnt = 4'(i);
            cyc("wrap_fetch",  1'b1, E_FETCH_RDY, K_FETCH);
            cyc("wrap_decode", 1'b1, E_DECODE,    K_ALU);
            cyc("wrap_addr",   1'b1, E_MEM_ADDR,  K_ALU);
            cyc("wrap_write",  1'b1, E_MEM_WRITE, K_CTL);
            check_ret("wrap_count", exp_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the multicycle RV64 datapath: PC, IR, register file, ALU, immediate generator and a single shared instruction/data memory port.
- Supports the implemented subset: ld (0000011), sd (0100011), beq (1100011) and R-type add/sub/and/or (0110011).
- Owns the memory request handshake, branch resolution, the illegal-opcode trap and a retired-instruction counter.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  7  IR[6:0], stable once DECODE is entered.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completion for the current request.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write (sd), 0 = read.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR from the memory read data.
- pc_en  out  1  PC register enable.
- pc_src  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target).
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = regA.
- alu_src_b  out  2  00 = regB, 01 = const 4, 10 = sign-extended immediate.
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct decode.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback select: 1 = MDR, 0 = ALUOut.
- halted  out  1  sticky trap flag.
- retired  out  CNT_WIDTH  count of completed instructions.

Behaviour:
- Reset: async assert forces state=FETCH, retired=0, halted=0, and all outputs to 0 while reset is high, including mid-transaction. A pending memory request is abandoned. The first cycle after release is FETCH with mem_req=1.
- Handshake: mem_req stays high in FETCH, MEM_READ and MEM_WRITE until mem_ready is sampled high. iord, mem_we and the ALU selects are held stable while mem_req=1. mem_ready outside these states is ignored.
- FETCH: mem_req=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_src=0. ir_write=pc_en=mem_ready (combinational gate). When mem_ready=1, go to DECODE; otherwise stay.
- DECODE: alu_src_a=01, alu_src_b=10, alu_op=00, precomputing the branch target into ALUOut. Next state:
  - ld/sd -> MEM_ADDR
  - R-type -> EXECUTE
  - beq -> BRANCH
  - any other opcode -> TRAP
- MEM_ADDR: alu_src_a=10, alu_src_b=10, alu_op=00. Next state is MEM_READ for ld, MEM_WRITE for sd.
- MEM_READ: mem_req=1, iord=1, mem_we=0. On mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1. Then -> FETCH.
- MEM_WRITE: mem_req=1, iord=1, mem_we=1. On mem_ready -> FETCH.
- EXECUTE: alu_src_a=10, alu_src_b=00, alu_op=10. Then -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. Then -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, pc_src=1, pc_en=zero. Then -> FETCH.
- TRAP: halted=1. All enables and requests are 0. Stays in TRAP until reset; retired is frozen.
- Latency with zero memory wait (mem_ready high in the first request cycle):
  - beq: 3 cycles
  - R-type and sd: 4 cycles
  - ld: 5 cycles
  - Each wait cycle adds 1 cycle.
- retired: increments by 1 on the final cycle of each instruction: MEM_WB, ALU_WB, BRANCH, or MEM_WRITE with mem_ready=1. Wraps from 2^CNT_WIDTH-1 to 0. Never increments in TRAP.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants OP_LD, OP_SD, OP_BEQ, OP_RTYPE
  - the state enum ctrl_state_t
  - the enums alu_op_t, src_a_t, src_b_t
- One natural sub-module: retire_counter (async-reset, wrap-around counter with an increment enable).

Test Plan:
- R-type with mem_ready tied 1: reset release, opcode=0110011 -> states FETCH, DECODE, EXECUTE, ALU_WB. reg_write=1 only in cycle 4. retired=1 after cycle 4.
- ld with 2 wait cycles on the data read: opcode=0000011, mem_ready low 2 cycles in MEM_READ -> 7 cycles total. iord=1 and mem_we=0 are held stable throughout. mem_to_reg=1 in MEM_WB.
- beq: opcode=1100011 with zero=1, then again with zero=0 -> pc_en=1 and pc_src=1 in BRANCH for the first; pc_en=0 in BRANCH for the second. 3 cycles each.
- Illegal opcode 0010011 -> TRAP after DECODE. halted=1, mem_req stays 0 for 20 cycles, retired unchanged. reset clears halted.
- Reset asserted mid MEM_WRITE with mem_req=1 -> mem_req drops in the same cycle (async). After release, state=FETCH and retired=0.
- Wrap: CNT_WIDTH=4, 16 back-to-back sd with mem_ready=1 -> retired counts 1..15, then reads 0.
